// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared widths and FIFO entry layout for pixel_stream_out
package pixel_stream_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 24;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             sof;
        logic             eol;
        logic             last_line;
    } pix_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with wrap-bit pointers
module sync_fifo #(
    parameter  int WIDTH = 27,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_stream_out.sv
// rtl/pixel_stream_out.sv - buffers raster pixel writes and re-emits them as a video stream
module pixel_stream_out
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 16
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               pix_wen,
    input  logic [RGB_W-1:0]   pix_rgb,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               pix_ready,
    output logic [RGB_W-1:0]   m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tuser,
    output logic               m_tlast,
    output logic               frame_done,
    output logic               ovf_err,
    output logic               seq_err
);

    localparam int                 CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    pix_entry_t         din;
    pix_entry_t         head;
    logic [CNT_W-1:0]   count;
    logic               fifo_full_unused;
    logic               empty;
    logic               in_range;
    logic               accept;
    logic               pop;
    logic [COORD_W-1:0] ex;
    logic [COORD_W-1:0] ey;

    assign in_range  = (pix_x <= X_LAST) && (pix_y <= Y_LAST);
    assign pix_ready = (count < CNT_W'(DEPTH));
    assign accept    = pix_wen && pix_ready && in_range;
    assign pop       = !empty && m_tready;

    always_comb begin
        din.rgb       = pix_rgb;
        din.sof       = (pix_x == '0) && (pix_y == '0);
        din.eol       = (pix_x == X_LAST);
        din.last_line = (pix_y == Y_LAST);
    end

    sync_fifo #(
        .WIDTH($bits(pix_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (aclk),
        .rst  (areset),
        .push (accept),
        .pop  (pop),
        .din  (din),
        .dout (head),
        .count(count),
        .full (fifo_full_unused),
        .empty(empty)
    );

    // Head fields are gated so the stream idles at zero rather than showing stale RAM.
    assign m_tvalid = !empty;
    assign m_tdata  = empty ? '0 : head.rgb;
    assign m_tuser  = !empty && head.sof;
    assign m_tlast  = !empty && head.eol;

    always_ff @(posedge aclk) begin
        if (areset) begin
            ex         <= '0;
            ey         <= '0;
            ovf_err    <= 1'b0;
            seq_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && head.eol && head.last_line;
            if (pix_wen && !pix_ready) begin
                ovf_err <= 1'b1;
            end
            if (pix_wen && pix_ready && !in_range) begin
                seq_err <= 1'b1;
            end
            if (accept) begin
                if ((pix_x != ex) || (pix_y != ey)) begin
                    seq_err <= 1'b1;
                end
                // Resynchronise from the received pixel so one glitch flags only once.
                if (pix_x != X_LAST) begin
                    ex <= pix_x + COORD_W'(1);
                    ey <= pix_y;
                end else begin
                    ex <= '0;
                    ey <= (pix_y == Y_LAST) ? '0 : pix_y + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_out.sv
// tb/tb_pixel_stream_out.sv - randomized self-checking bench for pixel_stream_out
module tb_pixel_stream_out;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int DEPTH  = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        pix_wen = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        m_tready = 1'b0;
    logic        pix_ready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        frame_done;
    logic        ovf_err;
    logic        seq_err;

    pixel_stream_out #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .DEPTH (DEPTH)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .pix_wen   (pix_wen),
        .pix_rgb   (pix_rgb),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_ready (pix_ready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .frame_done(frame_done),
        .ovf_err   (ovf_err),
        .seq_err   (seq_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [23:0] rgb;
        bit          sof;
        bit          eol;
        bit          last;
    } beat_t;

    beat_t q[$];
    int    ex;
    int    ey;
    bit    ovf_m;
    bit    seq_m;
    bit    fd_m;
    int    beats;
    int    fd_count;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs against the model, apply the model's view of the edge, check flags.
    task automatic tick();
        bit    ready_m;
        beat_t b;
        ready_m = (q.size() < DEPTH);
        check("pix_ready", pix_ready, ready_m);
        check("m_tvalid", m_tvalid, q.size() != 0);
        if (q.size() != 0) begin
            check("m_tdata", m_tdata, q[0].rgb);
            check("m_tuser", m_tuser, q[0].sof);
            check("m_tlast", m_tlast, q[0].eol);
        end
        fd_m = 1'b0;
        if (q.size() != 0 && m_tready) begin
            b = q.pop_front();
            fd_m = b.eol && b.last;
            beats++;
        end
        if (pix_wen) begin
            if (!ready_m) begin
                ovf_m = 1'b1;
            end else if (pix_x >= WIDTH || pix_y >= HEIGHT) begin
                seq_m = 1'b1;
            end else begin
                if (pix_x != ex || pix_y != ey) seq_m = 1'b1;
                b.rgb  = pix_rgb;
                b.sof  = (pix_x == 0) && (pix_y == 0);
                b.eol  = (pix_x == WIDTH - 1);
                b.last = (pix_y == HEIGHT - 1);
                q.push_back(b);
                if (pix_x < WIDTH - 1) begin
                    ex = pix_x + 1;
                    ey = pix_y;
                end else begin
                    ex = 0;
                    ey = (pix_y + 1) % HEIGHT;
                end
            end
        end
        @(posedge aclk);
        #1;
        check("frame_done", frame_done, fd_m);
        if (frame_done) fd_count++;
        check("ovf_err", ovf_err, ovf_m);
        check("seq_err", seq_err, seq_m);
    endtask

    task automatic put(input bit wen, input int x, input int y, input bit rdy);
        pix_wen  = wen;
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        pix_rgb  = 24'($urandom);
        m_tready = rdy;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && q.size() != 0; i++) put(1'b0, 0, 0, 1'b1);
        check("drain_timeout", q.size(), 0);
        put(1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        pix_wen = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        q.delete();
        ex = 0; ey = 0; ovf_m = 0; seq_m = 0; fd_m = 0;
        check("rst_pix_ready", pix_ready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_seq_err", seq_err, 0);
    endtask

    task automatic full_frame(input bit random_ready);
        int pos;
        beats = 0;
        fd_count = 0;
        pos = 0;
        for (int i = 0; i < 200 && pos < WIDTH * HEIGHT; i++) begin
            bit wen;
            wen = ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
            put(wen, pos % WIDTH, pos / WIDTH, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (wen) pos++;
        end
        drain();
        check("frame_beats", beats, WIDTH * HEIGHT);
        check("frame_done_count", fd_count, 1);
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        do_reset();

        full_frame(1'b0);

        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) put(1'b1, i % WIDTH, (i / WIDTH) % HEIGHT, 1'b0);
        check("ovf_flag", ovf_err, 1);
        beats = 0;
        drain();
        check("ovf_beats", beats, DEPTH);

        do_reset();
        put(1'b1, 0, 0, 1'b1);
        put(1'b1, 1, 0, 1'b1);
        check("seq_before", seq_err, 0);
        put(1'b1, 3, 0, 1'b1);
        check("seq_at_3_0", seq_err, 1);
        put(1'b1, 0, 1, 1'b1);
        drain();

        do_reset();
        begin
            int pos;
            pos = 0;
            beats = 0;
            for (int i = 0; i < 400; i++) begin
                bit wen;
                wen = $urandom_range(0, 1) && (q.size() < DEPTH);
                put(wen, pos % WIDTH, (pos / WIDTH) % HEIGHT, 1'($urandom_range(0, 1)));
                if (wen) pos++;
            end
            drain();
            check("stall_beats", beats, pos);
        end

        do_reset();
        for (int i = 0; i < 5; i++) put(1'b1, i % WIDTH, i / WIDTH, 1'b0);
        check("pre_reset_valid", m_tvalid, 1);
        do_reset();
        full_frame(1'b1);

        do_reset();
        put(1'b1, 0, 0, 1'b0);
        put(1'b1, 1, 0, 1'b0);
        put(1'b1, WIDTH, 0, 1'b0);
        check("oor_x_seq", seq_err, 1);
        put(1'b1, 0, HEIGHT, 1'b0);
        beats = 0;
        drain();
        check("oor_beats", beats, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_stream_out.md
# pixel_stream_out

Downstream stage of the Mandelbrot compute top level: it accepts the serialised pixel writes (`wEN`, `RGB_out`, `x_coord`, `y_coord`) and returns backpressure through `Ready`. Pixels are buffered in a small FIFO and re-emitted as an AXI4-Stream video stream, with `tuser` marking start-of-frame and `tlast` marking end-of-line. The block also checks that pixels arrive in raster order and reports overflow and ordering violations.

## Interface
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `DEPTH`, 16: FIFO entries; must be a power of two and at least 4.

- `aclk`  in  1  rising-edge clock.
- `areset`  in  1  synchronous, active-high reset.
- `pix_wen`  in  1  upstream pixel write strobe.
- `pix_rgb`  in  24  pixel colour, {R,G,B}.
- `pix_x`  in  10  pixel column.
- `pix_y`  in  10  pixel row.
- `pix_ready`  out  1  space available; drives upstream `Ready`.
- `m_tdata`  out  24  stream pixel.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tuser`  out  1  start of frame, asserted on pixel (0,0).
- `m_tlast`  out  1  end of line, asserted when x == WIDTH-1.
- `frame_done`  out  1  one-cycle pulse when pixel (WIDTH-1, HEIGHT-1) handshakes on the stream.
- `ovf_err`  out  1  sticky: a write was dropped.
- `seq_err`  out  1  sticky: a write broke raster order.

## Operation
- **Accept rule.** A write is accepted when `pix_wen && pix_ready && pix_x < WIDTH && pix_y < HEIGHT`.
- **Ready.** `pix_ready` = (count < DEPTH), where count is the registered FIFO occupancy. There is no full-bypass: a write is refused when the FIFO is full, even if a read happens in the same cycle.
- **Overflow.** `pix_wen` while `pix_ready` is low drops the pixel and sets `ovf_err`.
- **Out-of-range coordinates.** The pixel is dropped and `seq_err` is set. The expected-coordinate counters are not changed.
- **FIFO entry.** Each entry is {rgb, sof, eol}, 26 bits.
  - sof = (x==0 && y==0).
  - eol = (x==WIDTH-1).
- **Raster checker.** The expected coordinate (ex,ey) resets to (0,0).
  - On each accepted write, if (x,y) != (ex,ey), set `seq_err`. The pixel is still stored.
  - (ex,ey) is then resynchronised from the received pixel:
    - ex = x+1 and ey = y, when x < WIDTH-1;
    - otherwise ex = 0 and ey = y+1;
    - ey wraps from HEIGHT-1 to 0.
- **Stream output.** The FIFO is first-word-fall-through.
  - `m_tvalid` = FIFO not empty.
  - `m_tdata`, `m_tuser` and `m_tlast` come from the head entry.
  - Pop on `m_tvalid && m_tready`.
  - While `m_tvalid && !m_tready`, all m_* outputs stay stable.
- **Simultaneous push and pop.** When not full, the count is unchanged and both operations take effect.
- **Empty.** `m_tvalid` = 0; `m_tready` is ignored.
- **frame_done.** Pulses in the cycle after the handshake of a beat that has eol=1 and stored y == HEIGHT-1. The FIFO therefore also stores a last-line bit (27 bits total).
- **Error flags.** `ovf_err` and `seq_err` clear only on `areset`.

## Timing
- **Reset values.** `pix_ready`=1; `m_tvalid`, `m_tuser`, `m_tlast`, `frame_done`, `ovf_err`, `seq_err` = 0; `m_tdata`=0. Pointers, count and (ex,ey) are cleared.
- **Latency.** Write accepted at edge N into an empty FIFO → `m_tvalid`=1 after edge N.
- **Backpressure.** Push at edge N that fills the FIFO → `pix_ready` low after edge N. A pop at edge M re-raises it after edge M.
- **Error flags.** Set at the edge of the offending write.
- **Throughput.** One pixel per cycle in both directions.
- **Reset mid-frame.** FIFO contents are discarded, and `m_tvalid` is 0 in the cycle after the reset edge. The upstream must restart at (0,0).

## Structure
- **Package `pixel_stream_pkg`.**
  - `COORD_W`=10, `RGB_W`=24.
  - Typedef `pix_entry_t` = {rgb, sof, eol, last_line}.
- **Sub-module `sync_fifo`.**
  - Parameterised width and depth; pointers are log2(DEPTH)+1 bits.
  - Ports: push, pop, din, dout, count, full, empty.
- **Top.** Instantiates `sync_fifo` plus the accept logic, raster checker and `frame_done` register.

## Test plan
- **Full frame.** Full 4x3 frame (WIDTH=4, HEIGHT=3), `m_tready`=1 → 12 beats; `m_tuser` on beat 0; `m_tlast` on beats 3, 7, 11; one `frame_done` pulse after beat 11; errors stay 0.
- **Overflow.** Hold `m_tready`=0 and write 17 pixels with DEPTH=16 → `pix_ready` low after the 16th; 17th dropped; `ovf_err`=1. Releasing `m_tready` yields exactly 16 beats in order.
- **Ordering error.** Write (0,0),(1,0),(3,0),(0,1) with WIDTH=4 → `seq_err` set at (3,0); all 4 pixels are streamed; `m_tlast` on (3,0).
- **Stall stability.** `m_tready` toggled at random → `m_tdata`, `m_tuser` and `m_tlast` never change while `m_tvalid && !m_tready`; output order equals input order.
- **Reset mid-stream.** 5 pixels buffered, then `areset` for 1 cycle → `m_tvalid`=0, `pix_ready`=1, errors 0. The next frame from (0,0) streams cleanly.
- **Out of range.** `pix_x`=640 with WIDTH=640 → pixel dropped; `seq_err`=1; occupancy unchanged.
